image_line_feeder: RTL

- Hardware source for the image_top filter pipeline; replaces the bench-driven pixel feed.
- Reads 8-bit grey pixels from a 1-cycle-latency frame memory and streams them to image_top's subordinate AXI-stream port.
- Follows image_top's line-credit protocol: PREFILL_LINES lines are sent unconditionally, then one line per INT rising edge, then PAD_LINES all-zero lines to flush the line buffers.

---
 rtl/image_line_feeder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/image_line_feeder.sv
// Streams 8-bit grey pixels from a 1-cycle-latency frame memory into image_top's AXI-stream
// port. Prefill lines go out freely, later lines need an INT credit, then zero pad lines follow.
module image_line_feeder #(
  parameter int LINE_W        = 512,
  parameter int NUM_LINES     = 512,
  parameter int PREFILL_LINES = 4,
  parameter int PAD_LINES     = 2,
  parameter int ADDR_W        = 18
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              TVALID_man,
  output logic [7:0]        TDATA_man,
  output logic              TLAST_man,
  input  logic              TREADY_man,
  input  logic              INT
);

  localparam int PIX_W   = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int TOTAL   = NUM_LINES + PAD_LINES;
  localparam int LINE_CW = $clog2(TOTAL) + 1;

  localparam logic [PIX_W-1:0]   PIX_LAST     = PIX_W'(LINE_W - 1);
  localparam logic [LINE_CW-1:0] LINE_LAST    = LINE_CW'(TOTAL - 1);
  localparam logic [LINE_CW-1:0] LINE_PREFILL = LINE_CW'(PREFILL_LINES);
  localparam logic [LINE_CW-1:0] LINE_PAD     = LINE_CW'(NUM_LINES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]         state;
  logic [PIX_W-1:0]   pix_cnt;
  logic [LINE_CW-1:0] line_cnt;
  logic [1:0]         credits;
  logic [1:0]         credits_next;
  logic               int_q;
  logic               inflight;
  logic               inflight_pad;
  logic               inflight_last;
  logic [1:0]         fifo_count;
  logic [7:0]         fifo_data0;
  logic [7:0]         fifo_data1;
  logic               fifo_last0;
  logic               fifo_last1;

  logic       pop;
  logic       push;
  logic [7:0] push_data;
  logic [2:0] occ;
  logic       room;
  logic       line_start;
  logic       in_prefill;
  logic       gate_ok;
  logic       issue;
  logic       is_pad;
  logic       consume;
  logic       rise;
  logic       last_pop;

  assign TVALID_man = (fifo_count != 2'd0);
  assign TDATA_man  = fifo_data0;
  assign TLAST_man  = fifo_last0;
  assign pop        = TVALID_man & TREADY_man;

  // A slot is reserved at issue time so the FIFO can never overflow when the read returns.
  assign occ        = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign room       = (occ < 3'd2);
  assign line_start = (pix_cnt == '0);
  assign in_prefill = (line_cnt < LINE_PREFILL);
  assign gate_ok    = !line_start || in_prefill || (credits != 2'd0);
  assign issue      = (state == S_STREAM) && gate_ok && room;
  assign is_pad     = (line_cnt >= LINE_PAD);
  assign mem_en     = issue && !is_pad;
  assign consume    = issue && line_start && !in_prefill;
  assign rise       = INT && !int_q && (state != S_IDLE);

  assign last_pop = (state == S_DRAIN) && pop && (fifo_count == 2'd1) && !inflight;
  assign done     = last_pop;
  assign busy     = (state != S_IDLE) && !last_pop;

  assign push      = inflight;
  assign push_data = inflight_pad ? 8'h00 : mem_rdata;

  always_comb begin
    credits_next = credits;
    if (rise && !consume) begin
      if (credits != 2'd3) credits_next = credits + 2'd1;
    end else if (consume && !rise) begin
      credits_next = credits - 2'd1;
    end
  end

  // Control: FSM, counters, credits and the read-in-flight stage.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state         <= S_IDLE;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      credits       <= 2'd0;
      int_q         <= 1'b0;
      mem_addr      <= '0;
      inflight      <= 1'b0;
      inflight_pad  <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      int_q         <= INT;
      inflight      <= issue;
      inflight_pad  <= issue && is_pad;
      inflight_last <= issue && (pix_cnt == PIX_LAST);
      if (state != S_IDLE) credits <= credits_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_STREAM;
            pix_cnt  <= '0;
            line_cnt <= '0;
            credits  <= 2'd0;
            mem_addr <= '0;
          end
        end
        S_STREAM: begin
          if (issue) begin
            if (!is_pad) mem_addr <= mem_addr + ADDR_W'(1);
            if (pix_cnt == PIX_LAST) begin
              pix_cnt <= '0;
              if (line_cnt == LINE_LAST) begin
                line_cnt <= '0;
                state    <= S_DRAIN;
              end else begin
                line_cnt <= line_cnt + LINE_CW'(1);
              end
            end else begin
              pix_cnt <= pix_cnt + PIX_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (last_pop) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output FIFO: entry 0 is the stream head and only moves on a pop.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      fifo_count <= 2'd0;
      fifo_data0 <= 8'h00;
      fifo_data1 <= 8'h00;
      fifo_last0 <= 1'b0;
      fifo_last1 <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            fifo_data0 <= push_data;
            fifo_last0 <= inflight_last;
          end else begin
            fifo_data1 <= push_data;
            fifo_last1 <= inflight_last;
          end
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          fifo_data0 <= fifo_data1;
          fifo_last0 <= fifo_last1;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            fifo_data0 <= push_data;
            fifo_last0 <= inflight_last;
          end else begin
            fifo_data0 <= fifo_data1;
            fifo_last0 <= fifo_last1;
            fifo_data1 <= push_data;
            fifo_last1 <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
